// File: rtl/lanes_descrambler_if.sv
// Bus between the lanes deserializer, the per-lane descrambler and the
// receive decoder. Everything except clk/rst travels on this interface.
//
// Handshake: there is no ready/backpressure. word_valid is a one-cycle
// strobe that qualifies lane_x_in and gen_speed in the cycle it is high.
// out_valid is a one-cycle strobe that marks the cycle in which
// lane_x_out and sync_err carry a newly descrambled word. The consumer must
// take the word in that cycle.
interface lanes_descrambler_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 enable_dec;
    logic                 descr_rst;
    logic                 word_valid;
    logic [1:0]           gen_speed;
    logic [131:0]         lane_0_in;
    logic [131:0]         lane_1_in;
    logic [131:0]         lane_0_out;
    logic [131:0]         lane_1_out;
    logic                 out_valid;
    logic [1:0]           sync_err;
    logic [ERR_CNT_W-1:0] sync_err_cnt;

    // Upstream side: drives words in, observes descrambled words.
    modport master (
        output enable_dec, descr_rst, word_valid, gen_speed, lane_0_in, lane_1_in,
        input  lane_0_out, lane_1_out, out_valid, sync_err, sync_err_cnt
    );

    // Descrambler side.
    modport slave (
        input  enable_dec, descr_rst, word_valid, gen_speed, lane_0_in, lane_1_in,
        output lane_0_out, lane_1_out, out_valid, sync_err, sync_err_cnt
    );
endinterface

// File: rtl/lanes_descrambler.sv
// Two-lane descrambler. Each lane strips/checks its sync header and XORs
// the payload with the output of a 23-bit Fibonacci LFSR (keystream bit is
// lfsr[22]). Both lanes advance in lockstep and differ only in seed.
// Words come out one cycle after word_valid with a one-cycle out_valid.
module lanes_descrambler #(
    parameter logic [22:0] SEED_L0   = 23'h1DBFBC,
    parameter logic [22:0] SEED_L1   = 23'h0607BB,
    parameter int          ERR_CNT_W = 8
) (
    input logic clk,
    input logic rst,
    lanes_descrambler_if.slave bus
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    // Descramble one word starting from LFSR state st. Returns
    // {next_lfsr_state, descrambled_word}. Header bits (below lo) pass
    // through untouched; bits at or above hi are forced to zero.
    function automatic logic [154:0] descr_word(input logic [22:0]  st,
                                                 input logic [131:0] din,
                                                 input logic [1:0]   gen);
        logic [22:0]  l;
        logic [131:0] w;
        int           lo;
        int           hi;
        l = st;
        w = '0;
        case (gen)
            2'b01:   begin lo = 4; hi = 132; end
            2'b10:   begin lo = 2; hi = 66;  end
            default: begin lo = 0; hi = 8;   end
        endcase
        for (int i = 0; i < 132; i++) begin
            if (i < lo) begin
                w[i] = din[i];
            end else if (i < hi) begin
                w[i] = din[i] ^ l[22];
                l    = {l[21:0], l[22] ^ l[20] ^ l[15] ^ l[7] ^ l[4] ^ l[1]};
            end
        end
        return {l, w};
    endfunction

    // Header is legal only as one of the two alternating patterns; the
    // 8-bit mode carries no header and never flags an error.
    function automatic logic hdr_err(input logic [131:0] din, input logic [1:0] gen);
        logic e;
        case (gen)
            2'b01:   e = !((din[3:0] == 4'b0101) || (din[3:0] == 4'b1010));
            2'b10:   e = !((din[1:0] == 2'b01) || (din[1:0] == 2'b10));
            default: e = 1'b0;
        endcase
        return e;
    endfunction

    logic [22:0]          lfsr0_q, lfsr0_d;
    logic [22:0]          lfsr1_q, lfsr1_d;
    logic [131:0]         lane_0_out_q, lane_0_out_d;
    logic [131:0]         lane_1_out_q, lane_1_out_d;
    logic                 out_valid_q, out_valid_d;
    logic [1:0]           sync_err_q, sync_err_d;
    logic [ERR_CNT_W-1:0] sync_err_cnt_q, sync_err_cnt_d;

    logic [22:0]  base0;
    logic [22:0]  base1;
    logic [154:0] res0;
    logic [154:0] res1;
    logic [1:0]   err_now;

    // Datapath: a descr_rst arriving with a word means that word uses the seed.
    always_comb begin
        base0   = bus.descr_rst ? SEED_L0 : lfsr0_q;
        base1   = bus.descr_rst ? SEED_L1 : lfsr1_q;
        res0    = descr_word(base0, bus.lane_0_in, bus.gen_speed);
        res1    = descr_word(base1, bus.lane_1_in, bus.gen_speed);
        err_now = {hdr_err(bus.lane_1_in, bus.gen_speed),
                   hdr_err(bus.lane_0_in, bus.gen_speed)};
    end

    // Next state with priority !enable_dec > word_valid (incl. descr_rst) > descr_rst alone.
    always_comb begin
        lfsr0_d        = lfsr0_q;
        lfsr1_d        = lfsr1_q;
        lane_0_out_d   = lane_0_out_q;
        lane_1_out_d   = lane_1_out_q;
        out_valid_d    = 1'b0;
        sync_err_d     = sync_err_q;
        sync_err_cnt_d = sync_err_cnt_q;
        if (!bus.enable_dec) begin
            lfsr0_d      = SEED_L0;
            lfsr1_d      = SEED_L1;
            lane_0_out_d = '0;
            lane_1_out_d = '0;
            sync_err_d   = 2'b00;
        end else if (bus.word_valid) begin
            lfsr0_d      = res0[154:132];
            lfsr1_d      = res1[154:132];
            lane_0_out_d = res0[131:0];
            lane_1_out_d = res1[131:0];
            sync_err_d   = err_now;
            out_valid_d  = 1'b1;
            if ((err_now != 2'b00) && (sync_err_cnt_q != CNT_MAX)) begin
                sync_err_cnt_d = sync_err_cnt_q + 1'b1;
            end
        end else if (bus.descr_rst) begin
            lfsr0_d = SEED_L0;
            lfsr1_d = SEED_L1;
        end
    end

    // State registers; reset reseeds and clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr0_q        <= SEED_L0;
            lfsr1_q        <= SEED_L1;
            lane_0_out_q   <= '0;
            lane_1_out_q   <= '0;
            out_valid_q    <= 1'b0;
            sync_err_q     <= 2'b00;
            sync_err_cnt_q <= '0;
        end else begin
            lfsr0_q        <= lfsr0_d;
            lfsr1_q        <= lfsr1_d;
            lane_0_out_q   <= lane_0_out_d;
            lane_1_out_q   <= lane_1_out_d;
            out_valid_q    <= out_valid_d;
            sync_err_q     <= sync_err_d;
            sync_err_cnt_q <= sync_err_cnt_d;
        end
    end

    assign bus.lane_0_out   = lane_0_out_q;
    assign bus.lane_1_out   = lane_1_out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.sync_err     = sync_err_q;
    assign bus.sync_err_cnt = sync_err_cnt_q;

endmodule
